// File: rtl/uart_pkg.sv
// Shared UART framing definitions: FSM state encoding, oversample default and parity sense.
// The receiver imports the same package so both ends agree on framing.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int   UART_OVERSAMPLE  = 16;
  localparam logic UART_PARITY_EVEN = 1'b0;
  localparam logic UART_PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_transmitter_if.sv
// Byte-source side of the transmitter: valid/ready byte handshake plus the serial line and busy flag.
interface uart_transmitter_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] din;
  logic                 din_valid;
  logic                 din_ready;
  logic                 tx;
  logic                 busy;

  modport master (output din, output din_valid, input din_ready, input tx, input busy);
  modport slave  (input din, input din_valid, output din_ready, output tx, output busy);
endinterface

// File: rtl/uart_bit_timer.sv
// Counts s_tick pulses up to OVERSAMPLE and flags the clk edge that closes a bit period.
// bit_done_o is combinational so the owning FSM advances on exactly that edge.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  input  logic s_tick_i,
  output logic bit_done_o
);

  localparam int            TW   = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;

  assign bit_done_o = en_i && s_tick_i && (tick_cnt_q == LAST);

  // Clear wins so a tick landing on the accept edge is never counted.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (clr_i)
      tick_cnt_d = '0;
    else if (en_i && s_tick_i)
      tick_cnt_d = bit_done_o ? '0 : tick_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt_q <= '0;
    else        tick_cnt_q <= tick_cnt_d;
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: serialises accepted bytes as start/data/[parity]/stop frames, LSB first,
// one bit per OVERSAMPLE s_tick pulses. tx is registered and idles high.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_tick,
  uart_transmitter_if.slave   bus
);

  localparam int            BW        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);
  localparam logic          PAR_SENSE = (PARITY_ODD != 0) ? UART_PARITY_ODD : UART_PARITY_EVEN;

  uart_state_e          state_q, state_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;

  logic accept;
  logic bit_done;

  assign accept = bus.din_valid && (state_q == ST_IDLE);

  uart_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_bit_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (accept),
    .en_i       (state_q != ST_IDLE),
    .s_tick_i   (s_tick),
    .bit_done_o (bit_done)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shift_d    = bus.din;
          par_d      = (^bus.din) ^ PAR_SENSE;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (bit_done) begin
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BIT_LAST) begin
            stop_cnt_d = 1'b0;
            state_d    = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          stop_cnt_d = 1'b0;
          state_d    = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          if (stop_cnt_q == STOP_LAST) state_d    = ST_IDLE;
          else                         stop_cnt_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // tx is driven from the next state so each level appears on the edge that starts its bit.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.din_ready = (state_q == ST_IDLE);
  assign bus.tx        = tx_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: default 8N1, even-parity and odd-parity instances share
// clk/s_tick; frames are captured bit by bit at s_tick resolution and compared to hand-made vectors.
module tb_uart_transmitter;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic s_tick = 1'b0;
  logic tick_en = 1'b1;
  int   div    = 0;
  int   sel    = 0;
  int   n_chk  = 0;
  int   n_err  = 0;

  uart_transmitter_if #(.DATA_BITS(8)) if_d  ();
  uart_transmitter_if #(.DATA_BITS(8)) if_pe ();
  uart_transmitter_if #(.DATA_BITS(8)) if_po ();

  uart_transmitter #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0))
    u_def (.clk(clk), .rst_n(rst_n), .s_tick(s_tick), .bus(if_d));
  uart_transmitter #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(0))
    u_pe  (.clk(clk), .rst_n(rst_n), .s_tick(s_tick), .bus(if_pe));
  uart_transmitter #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(1))
    u_po  (.clk(clk), .rst_n(rst_n), .s_tick(s_tick), .bus(if_po));

  logic tx_sel, rdy_sel, busy_sel;
  assign tx_sel   = (sel == 0) ? if_d.tx        : (sel == 1) ? if_pe.tx        : if_po.tx;
  assign rdy_sel  = (sel == 0) ? if_d.din_ready : (sel == 1) ? if_pe.din_ready : if_po.din_ready;
  assign busy_sel = (sel == 0) ? if_d.busy      : (sel == 1) ? if_pe.busy      : if_po.busy;

  initial forever #5 clk = ~clk;

  // s_tick: one clk wide, every third clk, changing just after the rising edge
  initial forever begin
    @(posedge clk);
    #1;
    if (div == 2) begin div = 0; s_tick = tick_en; end
    else begin div = div + 1; s_tick = 1'b0; end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_valid(input int w, input logic v);
    case (w)
      0:       if_d.din_valid  = v;
      1:       if_pe.din_valid = v;
      default: if_po.din_valid = v;
    endcase
  endtask

  // Raise valid on a falling edge where the selected block is ready (and optionally s_tick is high),
  // so the accept happens on the next rising edge; returns 1 time unit after that edge.
  task automatic send(input int w, input logic [7:0] d, input bit align, input bit hold);
    int g;
    g   = 0;
    sel = w;
    @(negedge clk);
    while (!(rdy_sel && (!align || s_tick)) && g < 5000) begin
      @(negedge clk);
      g++;
    end
    chk("send_wait", (g >= 5000), 0);
    if_d.din  = d;
    if_pe.din = d;
    if_po.din = d;
    set_valid(w, 1'b1);
    @(posedge clk);
    #1;
    if (!hold) set_valid(w, 1'b0);
  endtask

  // Records one level per bit; each bit window is exactly 16 s_tick pulses after the previous one.
  // Returns on the falling edge before the edge that ends the last bit.
  task automatic capture(input int nbits, output logic [15:0] fr, output bit stab, output bit to);
    int   c;
    int   g;
    logic v;
    fr   = '0;
    stab = 1'b1;
    to   = 1'b0;
    for (int b = 0; b < nbits; b++) begin
      c = 0;
      g = 0;
      @(negedge clk);
      v = tx_sel;
      while (1) begin
        if (tx_sel !== v) stab = 1'b0;
        if (s_tick) c++;
        if (c == 16) break;
        g++;
        if (g > 2000) begin to = 1'b1; break; end
        @(negedge clk);
      end
      fr[b] = v;
      if (to) break;
    end
  endtask

  logic [15:0] fr;
  bit          stab, to;
  int          cnt, g;
  logic        v;
  logic [7:0]  lb_bytes [3];
  logic [9:0]  lb_frames [3];

  initial begin
    if_d.din = '0;  if_d.din_valid = 1'b0;
    if_pe.din = '0; if_pe.din_valid = 1'b0;
    if_po.din = '0; if_po.din_valid = 1'b0;
    lb_bytes[0] = 8'h3C; lb_frames[0] = 10'h278;
    lb_bytes[1] = 8'hC3; lb_frames[1] = 10'h386;
    lb_bytes[2] = 8'h55; lb_frames[2] = 10'h2AA;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", if_d.tx, 1);
    chk("rst_busy", if_d.busy, 0);
    chk("rst_par_tx", if_pe.tx, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ready", if_d.din_ready, 1);

    // single byte A5, default framing
    send(0, 8'hA5, 0, 0);
    chk("a5_tx_on_accept", tx_sel, 0);
    chk("a5_busy", busy_sel, 1);
    chk("a5_ready_low", rdy_sel, 0);
    capture(10, fr, stab, to);
    chk("a5_frame", fr[9:0], 10'h34A);
    chk("a5_stable", stab, 1);
    chk("a5_timeout", to, 0);
    chk("a5_busy_in_stop", busy_sel, 1);
    @(posedge clk);
    #1;
    chk("a5_busy_end", busy_sel, 0);
    chk("a5_ready_end", rdy_sel, 1);
    chk("a5_tx_idle", tx_sel, 1);

    // back-to-back 00 then FF with valid held; din changes mid-frame are ignored
    send(0, 8'h00, 0, 1);
    if_d.din = 8'hFF;
    capture(10, fr, stab, to);
    chk("b2b_f1", fr[9:0], 10'h200);
    chk("b2b_f1_stable", stab, 1);
    @(posedge clk);
    #1;
    chk("b2b_gap_tx", tx_sel, 1);
    chk("b2b_gap_ready", rdy_sel, 1);
    @(posedge clk);
    #1;
    chk("b2b_f2_start", tx_sel, 0);
    chk("b2b_f2_busy", busy_sel, 1);
    set_valid(0, 1'b0);
    capture(10, fr, stab, to);
    chk("b2b_f2", fr[9:0], 10'h3FE);
    chk("b2b_f2_stable", stab, 1);
    @(posedge clk);
    #1;
    chk("b2b_busy_end", busy_sel, 0);

    // parity: 07 -> even parity 1, odd parity 0, 11-bit frames
    send(1, 8'h07, 0, 0);
    capture(11, fr, stab, to);
    chk("par_even_frame", fr[10:0], 11'h60E);
    chk("par_even_stable", stab, 1);
    chk("par_even_busy_in_stop", busy_sel, 1);
    @(posedge clk);
    #1;
    chk("par_even_busy_end", busy_sel, 0);
    send(2, 8'h07, 0, 0);
    capture(11, fr, stab, to);
    chk("par_odd_frame", fr[10:0], 11'h40E);
    chk("par_odd_stable", stab, 1);
    @(posedge clk);
    #1;
    chk("par_odd_busy_end", busy_sel, 0);

    // handshake noise while busy, and an s_tick on the accept edge
    send(0, 8'h96, 1, 0);
    fork
      capture(10, fr, stab, to);
      begin
        repeat (150) begin
          @(negedge clk);
          if_d.din       = 8'($urandom);
          if_d.din_valid = ~if_d.din_valid;
        end
        if_d.din_valid = 1'b0;
      end
    join
    chk("hs_frame", fr[9:0], 10'h32C);
    chk("hs_stable", stab, 1);
    @(posedge clk);
    #1;
    chk("hs_busy_end", busy_sel, 0);

    // s_tick stuck low: frame stalls with tx held
    send(0, 8'hA5, 0, 0);
    repeat (100) @(posedge clk);
    tick_en = 1'b0;
    repeat (4) @(negedge clk);
    v   = tx_sel;
    cnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx_sel !== v) cnt++;
    end
    chk("stall_tx_held", cnt, 0);
    chk("stall_busy", busy_sel, 1);
    tick_en = 1'b1;
    g = 0;
    while (busy_sel && g < 3000) begin @(negedge clk); g++; end
    chk("stall_resume_done", busy_sel, 0);

    // reset during DATA bit 3 (frame bit 4): tx returns high without a clock edge
    send(0, 8'h00, 0, 0);
    cnt = 0;
    g   = 0;
    while (cnt < 72 && g < 2000) begin
      @(negedge clk);
      if (s_tick) cnt++;
      g++;
    end
    chk("mid_tx_before", tx_sel, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", tx_sel, 1);
    chk("mid_rst_busy", busy_sel, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_ready_after", rdy_sel, 1);
    chk("mid_busy_after", busy_sel, 0);
    cnt = 0;
    repeat (600) begin
      @(negedge clk);
      if (tx_sel !== 1'b1) cnt++;
    end
    chk("mid_no_resume", cnt, 0);

    // loopback: recover data field from captured frames in order
    for (int i = 0; i < 3; i++) begin
      send(0, lb_bytes[i], 0, 0);
      capture(10, fr, stab, to);
      chk("lb_dout", fr[8:1], lb_bytes[i]);
      chk("lb_frame", fr[9:0], lb_frames[i]);
      chk("lb_stable", stab, 1);
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
